// File: rtl/elevator_ctrl_if.sv
// Signal bundle between the elevator controller (master) and the cabin/shaft side (slave).
// Optional macro ELEV_ESTOP_EN adds the estop input.
interface elevator_ctrl_if #(
  parameter int FLOORS = 4
);
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

  logic [FLOORS-1:0] call;
  logic              door_closed;
`ifdef ELEV_ESTOP_EN
  logic              estop;
`endif
  logic [FW-1:0]     floor;
  logic [1:0]        motor;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  logic              dir_up;

`ifdef ELEV_ESTOP_EN
  modport master (
    input  call, door_closed, estop,
    output floor, motor, door_open, pending, dir_up
  );
  modport slave (
    output call, door_closed, estop,
    input  floor, motor, door_open, pending, dir_up
  );
`else
  modport master (
    input  call, door_closed,
    output floor, motor, door_open, pending, dir_up
  );
  modport slave (
    output call, door_closed,
    input  floor, motor, door_open, pending, dir_up
  );
`endif

endinterface

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: request latching, direction preference, travel/door timing.
// Optional macro ELEV_ESTOP_EN adds an emergency stop that freezes the car in place.
module elevator_ctrl #(
  parameter int FLOORS        = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int TRAVEL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  elevator_ctrl_if.master bus
);

  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVE_UP   = 2'd1;
  localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR_OPEN = 2'd3;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  localparam logic [FW-1:0] TOP_FLOOR   = FW'(FLOORS - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic              dir_up_q, dir_up_d;
  logic [TW-1:0]     travel_cnt_q, travel_cnt_d;
  logic [DW-1:0]     door_cnt_q, door_cnt_d;
  logic [1:0]        motor_q, motor_d;
  logic              door_open_q, door_open_d;

  logic              halt;
  logic [FLOORS-1:0] above_mask;
  logic [FLOORS-1:0] below_mask;
  logic [FLOORS-1:0] call_eff;
  logic              req_here;
  logic              req_above;
  logic              req_below;

`ifdef ELEV_ESTOP_EN
  assign halt = bus.estop;
`else
  assign halt = 1'b0;
`endif

  for (genvar gi = 0; gi < FLOORS; gi++) begin : g_floor_mask
    assign above_mask[gi] = (gi > int'(floor_q));
    assign below_mask[gi] = (gi < int'(floor_q));
  end

  assign req_here  = pending_q[floor_q];
  assign req_above = |(pending_q & above_mask);
  assign req_below = |(pending_q & below_mask);

  // A call at the current floor while the door is open only extends the door time.
  always_comb begin
    call_eff = bus.call;
    if (state_q == ST_DOOR_OPEN) begin
      call_eff[floor_q] = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;

    if (!halt) begin
      case (state_q)
        ST_IDLE: begin
          travel_cnt_d = '0;
          door_cnt_d   = '0;
          if (req_here) begin
            state_d = ST_DOOR_OPEN;
          end else if (bus.door_closed) begin
            if (req_above && (dir_up_q || !req_below)) begin
              state_d  = ST_MOVE_UP;
              dir_up_d = 1'b1;
            end else if (req_below) begin
              state_d  = ST_MOVE_DOWN;
              dir_up_d = 1'b0;
            end
          end
        end

        ST_MOVE_UP, ST_MOVE_DOWN: begin
          // An open door holds the travel count where it is.
          if (bus.door_closed) begin
            if (travel_cnt_q == TRAVEL_LAST) begin
              travel_cnt_d = '0;
              floor_d = (state_q == ST_MOVE_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
              if (pending_q[floor_d]) begin
                state_d = ST_DOOR_OPEN;
              end else if ((state_q == ST_MOVE_UP   && floor_d == TOP_FLOOR) ||
                           (state_q == ST_MOVE_DOWN && floor_d == '0)) begin
                state_d = ST_IDLE;
              end
            end else begin
              travel_cnt_d = travel_cnt_q + TW'(1);
            end
          end
        end

        default: begin
          if (bus.call[floor_q]) begin
            door_cnt_d = '0;
          end else if (door_cnt_q == DOOR_LAST) begin
            door_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            door_cnt_d = door_cnt_q + DW'(1);
          end
        end
      endcase
    end
  end

  // Serving a floor clears its request even if a new call arrives in the same cycle.
  always_comb begin
    pending_d = pending_q | call_eff;
    if (state_q != ST_DOOR_OPEN && state_d == ST_DOOR_OPEN) begin
      pending_d[floor_d] = 1'b0;
    end
  end

  always_comb begin
    motor_d     = MOTOR_STOP;
    door_open_d = 1'b0;
    if (!halt) begin
      door_open_d = (state_d == ST_DOOR_OPEN);
      if (bus.door_closed) begin
        if (state_d == ST_MOVE_UP) begin
          motor_d = MOTOR_UP;
        end else if (state_d == ST_MOVE_DOWN) begin
          motor_d = MOTOR_DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      floor_q      <= '0;
      pending_q    <= '0;
      dir_up_q     <= 1'b1;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
      motor_q      <= MOTOR_STOP;
      door_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      pending_q    <= pending_d;
      dir_up_q     <= dir_up_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
      motor_q      <= motor_d;
      door_open_q  <= door_open_d;
    end
  end

  assign bus.floor     = floor_q;
  assign bus.motor     = motor_q;
  assign bus.door_open = door_open_q;
  assign bus.pending   = pending_q;
  assign bus.dir_up    = dir_up_q;

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter FLOORS, default 4, number of floors served (2..16).
REQ-002 SHALL have parameter DOOR_CYCLES, default 8, clock cycles the door is held open (>=1).
REQ-003 SHALL have parameter TRAVEL_CYCLES, default 4, clock cycles to travel one floor (>=1).
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port call  input  FLOORS  one bit per floor, call/cabin request, sampled every clk.
REQ-007 SHALL have port door_closed  input  1  door sensor, 1 = closed.
REQ-008 SHALL have port floor  output  FW  current floor index, FW = max(1, clog2(FLOORS)).
REQ-009 SHALL have port motor  output  2  00 stop, 01 up, 10 down, 11 never driven.
REQ-010 SHALL have port door_open  output  1  door open command.
REQ-011 SHALL have port pending  output  FLOORS  latched outstanding requests.
REQ-012 SHALL have port dir_up  output  1  travel preference, 1 = up.

Function
REQ-013 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; all outputs registered, no combinational input-to-output path.
REQ-014 SHALL set pending[i] one cycle after call[i]=1, except call at floor while in DOOR_OPEN (REQ-020).
REQ-015 SHALL clear pending[floor] on entry to DOOR_OPEN; a clear in the same cycle as a new call on that floor wins.
REQ-016 IDLE: motor=00, door_open=0; if pending[floor] -> DOOR_OPEN next cycle, regardless of door_closed.
REQ-017 IDLE, door_closed=1, no request at floor: requests above and (dir_up=1 or none below) -> MOVE_UP, dir_up=1; else requests below -> MOVE_DOWN, dir_up=0; else stay, dir_up unchanged.
REQ-018 MOVE_x: motor=01/10; travel counter increments each cycle with door_closed=1; after TRAVEL_CYCLES counts floor +/-1, counter clears.
REQ-019 On arrival: pending[new floor] -> DOOR_OPEN; else continue in same direction.
REQ-020 DOOR_OPEN: door_open=1, motor=00, counts DOOR_CYCLES cycles then -> IDLE; call[floor]=1 restarts count, does not set pending.
REQ-021 Safety interlock: door_closed=0 in MOVE_x forces motor=00 and holds travel counter; resumes when door_closed=1.
REQ-022 floor SHALL never go below 0 or above FLOORS-1; call bits for nonexistent floors do not exist (width = FLOORS).

Reset
REQ-023 rst=1 SHALL immediately force IDLE, floor=0, motor=00, door_open=0, pending=0, dir_up=1, counters=0, including mid-travel or mid-door.
REQ-024 First state change SHALL occur on the first clk edge after rst deasserts.

Configuration
REQ-025 Macro ELEV_ESTOP_EN SHALL, when defined, add input estop (1 bit, after door_closed).
REQ-026 With ELEV_ESTOP_EN, estop=1 forces motor=00, door_open=0, freezes state, floor, counters, dir_up; pending still latches calls; release resumes exactly where frozen.
REQ-027 Without ELEV_ESTOP_EN, port estop SHALL not exist, behaviour per REQ-013..022.

Verification (FLOORS=4, DOOR_CYCLES=3, TRAVEL_CYCLES=2)
REQ-028 Reset, door_closed=1, call=0100 one cycle -> pending=0100, MOVE_UP, floor 0->1->2 every 2 cycles, DOOR_OPEN at floor 2 for 3 cycles, pending=0000, IDLE.
REQ-029 At floor 0 moving up to 3, call=0010 while between 0 and 1 -> stops at 1 (door 3 cycles), then continues to 3.
REQ-030 At floor 2 dir_up=1, pending=1001 -> goes up to 3 first, then down to 0.
REQ-031 During MOVE_UP, door_closed=0 for 5 cycles -> motor=00, floor frozen 5 cycles, then resumes with remaining travel count.
REQ-032 In DOOR_OPEN at floor 1, call=0010 at count 2 -> door held 3 further cycles, pending[1]=0; assert rst mid-travel -> floor=0, IDLE next sample.
REQ-033 With ELEV_ESTOP_EN, estop=1 mid-travel for 4 cycles, call=1000 meanwhile -> all frozen, pending[3]=1, travel resumes on release.
